phy_rx_link_ctrl: RTL and testbench
===================================

// Module: phy_rx_link_ctrl
// PURPOSE
//   Link-training and supervision controller for the two-lane PCIe receive PHY, in the clk_4f domain.
//   Takes per-lane active/valid status from both serial_paralelo lanes and runs a training FSM.
//   Declares link-up, gates downstream valid (demux_8_32 / mux_striping), and handles lane loss/skew by retraining.
//   After MAX_RETRY failed attempts the controller enters a sticky fault state.
// PARAMETERS
//   ALIGN_CNT     4    consecutive cycles with both lanes valid required before LINK_UP
//   MAX_SKEW      3    single-lane-valid cycles tolerated during ALIGN before RECOVERY
//   TIMEOUT       64   cycles allowed in WAIT_ACTIVE before RECOVERY
//   RECOVERY_WAIT 8    cycles held in RECOVERY before returning to WAIT_ACTIVE
//   MAX_RETRY     3    RECOVERY entries that cause FAULT
// PORTS
//   clk_4f        in   1  sole clock, byte rate of serial_paralelo
//   reset         in   1  synchronous, active-low
//   enable        in   1  1 = train/run link; 0 = force DISABLED
//   active_0      in   1  lane 0 active_serial_paralelo
//   active_1      in   1  lane 1 active_serial_paralelo
//   valid_0       in   1  lane 0 valid_serial_paralelo
//   valid_1       in   1  lane 1 valid_serial_paralelo
//   link_up       out  1  1 only in LINK_UP
//   rx_gate       out  1  valid gate for demux/mux; equals link_up, registered same cycle
//   state         out  3  0 DISABLED, 1 WAIT_ACTIVE, 2 ALIGN, 3 LINK_UP, 4 RECOVERY, 5 FAULT
//   retrain_cnt   out  8  RECOVERY entries since DISABLED; saturates at 255
//   lane_err      out  2  sticky; bit i set when lane i caused a RECOVERY (drop or lone valid)
//   fault         out  1  1 only in FAULT
// BEHAVIOUR
//   - All outputs registered. Sample at posedge clk_4f with reset==0: state=0, all outputs 0, all counters 0.
//   - enable==0 (any state, reset high): next state DISABLED; timer, good and skew counters, retrain_cnt, lane_err cleared.
//     Priority: reset > enable > FSM.
//   - DISABLED: enable==1 -> WAIT_ACTIVE, timer=0.
//   - WAIT_ACTIVE: timer++ each cycle.
//     - active_0&active_1 -> ALIGN; good=0, skew=0.
//     - else timer==TIMEOUT-1 -> RECOVERY; lane_err |= {~active_1,~active_0}.
//   - ALIGN:
//     - Either active low -> RECOVERY; lane_err set for the dropped lane(s).
//     - valid_0&valid_1 -> good++; good reaching ALIGN_CNT-1 in this cycle -> LINK_UP.
//       Result: link_up rises exactly ALIGN_CNT cycles after the first both-valid cycle.
//     - Exactly one valid -> good=0, skew++; skew==MAX_SKEW in this cycle -> RECOVERY; lane_err set for the valid lane.
//     - Neither valid: counters hold.
//   - LINK_UP: link_up=rx_gate=1.
//     - active drop, or valid_0!=valid_1 -> RECOVERY next edge; link_up falls the same edge (no extra gated cycle).
//     - Lane blame: the dropped lane, or the lane whose valid was high.
//   - RECOVERY:
//     - On entry: retrain_cnt += 1 (saturating).
//     - If post-increment count >= MAX_RETRY -> FAULT next edge.
//     - Otherwise hold RECOVERY_WAIT cycles, then WAIT_ACTIVE with timer=0.
//   - FAULT: fault=1, link_up=0. Exit only via enable==0 or reset.
//   - Simultaneous drop on both lanes: both lane_err bits set. Drop and mismatch together: a single RECOVERY entry.
//   - Reset asserted mid-LINK_UP: link_up is 0 on the next edge. No partial state survives.
//   - Counters must not wrap. timer width >= clog2(TIMEOUT+1); retrain_cnt saturates at 8'hFF.
// TESTING
//   1. reset low 2 cycles, enable=1, both active, both valid from cycle 3
//      -> state 1->2->3; link_up=1 exactly 4 cycles after the first both-valid cycle; retrain_cnt=0.
//   2. From LINK_UP, drop active_1 for 1 cycle
//      -> link_up=0 next edge, state=4, lane_err=2'b10, retrain_cnt=1.
//      Restore lane 1 -> back to LINK_UP after 8+1+4 cycles.
//   3. In ALIGN, valid_0 only for 3 cycles
//      -> RECOVERY on the 3rd, lane_err=2'b01.
//      2 lone-valid cycles then both valid -> no RECOVERY; good counter restarts.
//   4. Keep active_0=0 with enable=1
//      -> RECOVERY after 64 cycles, 3 times; then state=5, fault=1, retrain_cnt=3.
//      enable=0 -> state=0, all cleared.
//   5. Assert reset in LINK_UP, and separately enable=0 in ALIGN
//      -> next edge state=0 and all outputs 0.
//   6. Random active/valid toggling, 10k cycles
//      -> checks: link_up==(state==3); rx_gate==link_up; fault==(state==5); retrain_cnt never decreases unless cleared.

Source files
------------

// File: rtl/phy_rx_link_ctrl.sv
// rtl/phy_rx_link_ctrl.sv - two-lane receive PHY link training and supervision FSM
module phy_rx_link_ctrl #(
  parameter int ALIGN_CNT     = 4,
  parameter int MAX_SKEW      = 3,
  parameter int TIMEOUT       = 64,
  parameter int RECOVERY_WAIT = 8,
  parameter int MAX_RETRY     = 3
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic       enable,
  input  logic       active_0,
  input  logic       active_1,
  input  logic       valid_0,
  input  logic       valid_1,
  output logic       link_up,
  output logic       rx_gate,
  output logic [2:0] state,
  output logic [7:0] retrain_cnt,
  output logic [1:0] lane_err,
  output logic       fault
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(ALIGN_CNT + 1);
  localparam int SW = $clog2(MAX_SKEW + 1);
  localparam int RW = $clog2(RECOVERY_WAIT + 1);

  typedef enum logic [2:0] {
    S_DIS   = 3'd0,
    S_WAIT  = 3'd1,
    S_ALIGN = 3'd2,
    S_UP    = 3'd3,
    S_REC   = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t        state_q, state_n;
  logic [TW-1:0] timer_q, timer_n;
  logic [GW-1:0] good_q, good_n;
  logic [SW-1:0] skew_q, skew_n;
  logic [RW-1:0] rwait_q, rwait_n;
  logic [7:0]    retrain_n;
  logic [1:0]    lane_err_n;
  logic          go_rec;
  logic [1:0]    blame;
  logic [1:0]    drop;
  logic [1:0]    vbits;
  logic          lone;

  assign drop  = {~active_1, ~active_0};
  assign vbits = {valid_1, valid_0};
  assign lone  = valid_0 ^ valid_1;
  assign state = state_q;

  always_comb begin
    state_n    = state_q;
    timer_n    = timer_q;
    good_n     = good_q;
    skew_n     = skew_q;
    rwait_n    = rwait_q;
    retrain_n  = retrain_cnt;
    lane_err_n = lane_err;
    go_rec     = 1'b0;
    blame      = 2'b00;
    if (!enable) begin
      state_n    = S_DIS;
      timer_n    = '0;
      good_n     = '0;
      skew_n     = '0;
      rwait_n    = '0;
      retrain_n  = '0;
      lane_err_n = '0;
    end else begin
      case (state_q)
        S_DIS: begin
          state_n = S_WAIT;
          timer_n = '0;
        end
        S_WAIT: begin
          timer_n = timer_q + TW'(1);
          if (active_0 && active_1) begin
            state_n = S_ALIGN;
            good_n  = '0;
            skew_n  = '0;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            go_rec = 1'b1;
            blame  = drop;
          end
        end
        S_ALIGN: begin
          if (|drop) begin
            go_rec = 1'b1;
            blame  = drop;
          end else if (valid_0 && valid_1) begin
            if (good_q == GW'(ALIGN_CNT - 1)) state_n = S_UP;
            else good_n = good_q + GW'(1);
          end else if (lone) begin
            // Skew tolerance is cumulative over the whole ALIGN visit.
            good_n = '0;
            if (skew_q == SW'(MAX_SKEW - 1)) begin
              go_rec = 1'b1;
              blame  = vbits;
            end else begin
              skew_n = skew_q + SW'(1);
            end
          end
        end
        S_UP: begin
          if (|drop) begin
            go_rec = 1'b1;
            blame  = drop;
          end else if (lone) begin
            go_rec = 1'b1;
            blame  = vbits;
          end
        end
        S_REC: begin
          if (retrain_cnt >= 8'(MAX_RETRY)) begin
            state_n = S_FAULT;
          end else if (rwait_q == RW'(RECOVERY_WAIT - 1)) begin
            state_n = S_WAIT;
            timer_n = '0;
          end else begin
            rwait_n = rwait_q + RW'(1);
          end
        end
        S_FAULT: state_n = S_FAULT;
        default: state_n = S_DIS;
      endcase
      if (go_rec) begin
        state_n    = S_REC;
        rwait_n    = '0;
        lane_err_n = lane_err | blame;
        if (retrain_cnt != 8'hFF) retrain_n = retrain_cnt + 8'd1;
      end
    end
  end

  // Flags decode the next state so they change on the same edge as state.
  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      state_q     <= S_DIS;
      timer_q     <= '0;
      good_q      <= '0;
      skew_q      <= '0;
      rwait_q     <= '0;
      retrain_cnt <= '0;
      lane_err    <= '0;
      link_up     <= 1'b0;
      rx_gate     <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state_q     <= state_n;
      timer_q     <= timer_n;
      good_q      <= good_n;
      skew_q      <= skew_n;
      rwait_q     <= rwait_n;
      retrain_cnt <= retrain_n;
      lane_err    <= lane_err_n;
      link_up     <= (state_n == S_UP);
      rx_gate     <= (state_n == S_UP);
      fault       <= (state_n == S_FAULT);
    end
  end

endmodule

// File: tb/tb_phy_rx_link_ctrl.sv
// tb/tb_phy_rx_link_ctrl.sv - self-checking bench for phy_rx_link_ctrl
module tb_phy_rx_link_ctrl;

  localparam int ALIGN_CNT     = 4;
  localparam int MAX_SKEW      = 3;
  localparam int TIMEOUT       = 64;
  localparam int RECOVERY_WAIT = 8;
  localparam int MAX_RETRY     = 3;

  logic       clk_4f = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       active_0 = 1'b0, active_1 = 1'b0;
  logic       valid_0 = 1'b0, valid_1 = 1'b0;
  logic       link_up, rx_gate, fault;
  logic [2:0] state;
  logic [7:0] retrain_cnt;
  logic [1:0] lane_err;

  int checks = 0;
  int passed = 0;

  phy_rx_link_ctrl #(
    .ALIGN_CNT(ALIGN_CNT), .MAX_SKEW(MAX_SKEW), .TIMEOUT(TIMEOUT),
    .RECOVERY_WAIT(RECOVERY_WAIT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk_4f(clk_4f), .reset(reset), .enable(enable),
    .active_0(active_0), .active_1(active_1), .valid_0(valid_0), .valid_1(valid_1),
    .link_up(link_up), .rx_gate(rx_gate), .state(state),
    .retrain_cnt(retrain_cnt), .lane_err(lane_err), .fault(fault)
  );

  always #5 clk_4f = ~clk_4f;

  // Reference model: phase number plus counts of cycles spent, in plain integers.
  int m_phase = 0;
  int m_waited = 0;
  int m_good_run = 0;
  int m_lone_seen = 0;
  int m_rec_cycles = 0;
  int m_retries = 0;
  logic [1:0] m_err = 2'b00;

  always @(posedge clk_4f) begin
    int go_rec;
    logic [1:0] who;
    go_rec = 0;
    who = 2'b00;
    if (!reset || !enable) begin
      m_phase = 0; m_waited = 0; m_good_run = 0; m_lone_seen = 0;
      m_rec_cycles = 0; m_retries = 0; m_err = 2'b00;
    end else begin
      case (m_phase)
        0: begin m_phase = 1; m_waited = 0; end
        1: begin
          m_waited++;
          if (active_0 && active_1) begin
            m_phase = 2; m_good_run = 0; m_lone_seen = 0;
          end else if (m_waited == TIMEOUT) begin
            go_rec = 1; who = {!active_1, !active_0};
          end
        end
        2: begin
          if (!active_0 || !active_1) begin
            go_rec = 1; who = {!active_1, !active_0};
          end else if (valid_0 && valid_1) begin
            m_good_run++;
            if (m_good_run == ALIGN_CNT) m_phase = 3;
          end else if (valid_0 != valid_1) begin
            m_good_run = 0;
            m_lone_seen++;
            if (m_lone_seen == MAX_SKEW) begin go_rec = 1; who = {valid_1, valid_0}; end
          end
        end
        3: begin
          if (!active_0 || !active_1) begin
            go_rec = 1; who = {!active_1, !active_0};
          end else if (valid_0 != valid_1) begin
            go_rec = 1; who = {valid_1, valid_0};
          end
        end
        4: begin
          m_rec_cycles++;
          if (m_retries >= MAX_RETRY) m_phase = 5;
          else if (m_rec_cycles == RECOVERY_WAIT) begin m_phase = 1; m_waited = 0; end
        end
        default: ;
      endcase
      if (go_rec != 0) begin
        m_phase = 4; m_rec_cycles = 0; m_err = m_err | who;
        if (m_retries < 255) m_retries++;
      end
    end
  end

  task automatic edge1();
    @(posedge clk_4f);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1;
    active_0 = 1'b1; active_1 = 1'b1; valid_0 = 1'b1; valid_1 = 1'b1;
    edge1();
    edge1();
    checks++;
    if ({state, link_up, rx_gate, retrain_cnt, lane_err, fault} !== 15'd0)
      $display("FAIL reset_state: got st=%0d lu=%b gate=%b rc=%0d le=%b f=%b, want all 0",
               state, link_up, rx_gate, retrain_cnt, lane_err, fault);
    else passed++;
  endtask

  task automatic test_training();
    int exp_st[6] = '{1, 2, 2, 2, 2, 3};
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      edge1();
      checks++;
      if (state !== 3'(exp_st[i]) || link_up !== (exp_st[i] == 3))
        $display("FAIL train_seq[%0d]: got st=%0d lu=%b, want st=%0d lu=%b",
                 i, state, link_up, exp_st[i], exp_st[i] == 3);
      else passed++;
    end
    checks++;
    if (rx_gate !== 1'b1 || retrain_cnt !== 8'd0 || fault !== 1'b0)
      $display("FAIL train_up: got gate=%b rc=%0d f=%b, want 1 0 0", rx_gate, retrain_cnt, fault);
    else passed++;
  endtask

  task automatic test_lane_drop();
    active_1 = 1'b0;
    edge1();
    checks++;
    if (state !== 3'd4 || link_up !== 1'b0 || rx_gate !== 1'b0 || lane_err !== 2'b10 || retrain_cnt !== 8'd1)
      $display("FAIL drop_rec: got st=%0d lu=%b gate=%b le=%b rc=%0d, want 4 0 0 10 1",
               state, link_up, rx_gate, lane_err, retrain_cnt);
    else passed++;
    active_1 = 1'b1;
    for (int i = 1; i <= RECOVERY_WAIT + 1 + ALIGN_CNT; i++) begin
      edge1();
      if (i == RECOVERY_WAIT + ALIGN_CNT) begin
        checks++;
        if (state !== 3'd2) $display("FAIL drop_relink_early: got st=%0d, want 2", state);
        else passed++;
      end
    end
    checks++;
    if (state !== 3'd3 || link_up !== 1'b1)
      $display("FAIL drop_relink: got st=%0d lu=%b, want 3 1", state, link_up);
    else passed++;
  endtask

  task automatic test_skew();
    enable = 1'b0; edge1();
    checks++;
    if (state !== 3'd0 || retrain_cnt !== 8'd0 || lane_err !== 2'b00)
      $display("FAIL skew_clear: got st=%0d rc=%0d le=%b, want 0 0 00", state, retrain_cnt, lane_err);
    else passed++;
    enable = 1'b1; valid_0 = 1'b0; valid_1 = 1'b0;
    edge1(); edge1();
    valid_0 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      edge1();
      checks++;
      if (state !== ((i == 3) ? 3'd4 : 3'd2))
        $display("FAIL skew_lone[%0d]: got st=%0d, want %0d", i, state, (i == 3) ? 4 : 2);
      else passed++;
    end
    checks++;
    if (lane_err !== 2'b01) $display("FAIL skew_blame: got le=%b, want 01", lane_err);
    else passed++;
    enable = 1'b0; valid_0 = 1'b0; edge1();
    enable = 1'b1; edge1(); edge1();
    valid_0 = 1'b1;
    edge1(); edge1();
    valid_1 = 1'b1;
    for (int i = 1; i <= ALIGN_CNT; i++) begin
      edge1();
      checks++;
      if (state !== ((i == ALIGN_CNT) ? 3'd3 : 3'd2))
        $display("FAIL skew_tolerate[%0d]: got st=%0d, want %0d", i, state, (i == ALIGN_CNT) ? 3 : 2);
      else passed++;
    end
    checks++;
    if (lane_err !== 2'b00 || retrain_cnt !== 8'd0)
      $display("FAIL skew_tolerate_err: got le=%b rc=%0d, want 00 0", lane_err, retrain_cnt);
    else passed++;
  endtask

  task automatic test_timeout_fault();
    int edges, recs;
    logic [2:0] prev;
    enable = 1'b0; edge1();
    enable = 1'b1; active_0 = 1'b0; active_1 = 1'b1;
    edges = 0; recs = 0; prev = state;
    while (state !== 3'd5 && edges < 400) begin
      edge1();
      edges++;
      if (state == 3'd4 && prev != 3'd4) recs++;
      prev = state;
    end
    checks++;
    if (edges !== 210 || recs !== 3)
      $display("FAIL timeout_count: got edges=%0d recs=%0d, want 210 3", edges, recs);
    else passed++;
    checks++;
    if (fault !== 1'b1 || retrain_cnt !== 8'd3 || link_up !== 1'b0 || lane_err !== 2'b01)
      $display("FAIL timeout_fault: got f=%b rc=%0d lu=%b le=%b, want 1 3 0 01",
               fault, retrain_cnt, link_up, lane_err);
    else passed++;
    active_0 = 1'b1;
    edge1();
    checks++;
    if (state !== 3'd5) $display("FAIL fault_sticky: got st=%0d, want 5", state);
    else passed++;
    enable = 1'b0; edge1();
    checks++;
    if ({state, link_up, rx_gate, retrain_cnt, lane_err, fault} !== 15'd0)
      $display("FAIL fault_clear: got st=%0d rc=%0d le=%b f=%b, want all 0", state, retrain_cnt, lane_err, fault);
    else passed++;
  endtask

  task automatic test_abort();
    enable = 1'b1; active_0 = 1'b1; active_1 = 1'b1; valid_0 = 1'b1; valid_1 = 1'b1;
    repeat (6) edge1();
    checks++;
    if (state !== 3'd3) $display("FAIL abort_pre_up: got st=%0d, want 3", state);
    else passed++;
    reset = 1'b0; edge1();
    checks++;
    if ({state, link_up, rx_gate, retrain_cnt, lane_err, fault} !== 15'd0)
      $display("FAIL reset_in_up: got st=%0d lu=%b gate=%b, want all 0", state, link_up, rx_gate);
    else passed++;
    reset = 1'b1; valid_1 = 1'b0;
    edge1(); edge1(); edge1();
    valid_1 = 1'b1;
    edge1(); edge1();
    checks++;
    if (state !== 3'd2) $display("FAIL abort_pre_align: got st=%0d, want 2", state);
    else passed++;
    enable = 1'b0; edge1();
    checks++;
    if ({state, link_up, rx_gate, retrain_cnt, lane_err, fault} !== 15'd0)
      $display("FAIL disable_in_align: got st=%0d lu=%b, want all 0", state, link_up);
    else passed++;
    enable = 1'b1;
    repeat (6) edge1();
    checks++;
    if (state !== 3'd3) $display("FAIL retrain_fresh: got st=%0d, want 3", state);
    else passed++;
  endtask

  task automatic test_random();
    logic [7:0] prev_rc;
    logic       cleared;
    prev_rc = retrain_cnt;
    cleared = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      reset    = ($urandom_range(0, 999) != 0);
      enable   = ($urandom_range(0, 299) != 0);
      active_0 = ($urandom_range(0, 99) < 98);
      active_1 = ($urandom_range(0, 99) < 98);
      if ($urandom_range(0, 99) < 85) begin valid_0 = 1'b1; valid_1 = 1'b1; end
      else begin valid_0 = 1'($urandom); valid_1 = 1'($urandom); end
      cleared = !reset || !enable;
      edge1();
      checks++;
      if ({state, retrain_cnt, lane_err} !== {3'(m_phase), 8'(m_retries), m_err})
        $display("FAIL rand_model[%0d]: got st=%0d rc=%0d le=%b, want st=%0d rc=%0d le=%b",
                 i, state, retrain_cnt, lane_err, m_phase, m_retries, m_err);
      else passed++;
      checks++;
      if (link_up !== (state == 3'd3) || rx_gate !== link_up || fault !== (state == 3'd5))
        $display("FAIL rand_flags[%0d]: got st=%0d lu=%b gate=%b f=%b", i, state, link_up, rx_gate, fault);
      else passed++;
      checks++;
      if (!cleared && retrain_cnt < prev_rc)
        $display("FAIL rand_monotonic[%0d]: got rc=%0d after %0d", i, retrain_cnt, prev_rc);
      else passed++;
      prev_rc = retrain_cnt;
    end
  endtask

  initial begin
    test_reset();
    test_training();
    test_lane_drop();
    test_skew();
    test_timeout_fault();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
